x2050pri: RTL and testbench
===========================

Name: x2050pri

Overview:
- Channel-priority scheduler for the 2050 break-in mechanism.
- Collects routine requests from NCH channels: index 0 is selector channel 1 (highest fixed priority), and index NCH-1 is the multiplexor channel (lowest).
- Picks one winner, latches its identity, and drives the single routine-request line into the break-in logic. It holds that line until the break-in is gated, then tracks the routine until last cycle or break-out.
- Per-channel wait counters stop lower channels from starving under continuous high-priority traffic.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- IDW, 2, width of the grant id; must satisfy 2**IDW >= NCH.
- MAXWAIT, 3, number of times a pending channel may be passed over before it is boosted (1..15).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ros_advance  in  1  ROS cycle advance. All state changes are qualified by this signal.
- i_req  in  NCH  level routine request, one bit per channel.
- i_gate_break_routine  in  1  break-in logic has accepted the request (routine gated in).
- i_last_cycle  in  1  current routine is in its last cycle (CG=3).
- i_break_out  in  1  routine is breaking out (ZF=14 in routine mode).
- i_chain  in  1  break-in logic is chaining directly into another routine.
- o_routine_request  out  1  request into the break-in logic.
- o_grant_id  out  IDW  latched winner id; valid when o_grant_valid=1.
- o_grant_valid  out  1  asserted in PEND and RUN.
- o_ack  out  NCH  one-hot, one-clock pulse to the channel whose routine was gated in.
- o_busy  out  1  asserted in RUN.
- o_boosted  out  1  current grant was chosen by starvation boost.

Behaviour:
- Reset values: state=IDLE; all outputs 0; all wait counters 0. Reset overrides every other input in the same cycle.
- When i_ros_advance=0, all registers hold, including the counters. o_ack still clears on the following clock, so it is always a single-clock pulse.
- States: IDLE, PEND, RUN (2-bit encoding).
- Arbitration function:
  - If any channel has a set i_req bit and wait==MAXWAIT, the winner is the lowest such index, and o_boosted=1.
  - Otherwise the winner is the lowest index with i_req set, and o_boosted=0.
- IDLE: if any i_req bit is set, latch the winner into o_grant_id and go to PEND. Latency is 1 advance cycle from request to o_routine_request.
- PEND: o_routine_request=1.
  - If i_gate_break_routine: go to RUN, and o_ack[o_grant_id]=1 on the next clock.
  - Else if i_req[o_grant_id]=0 (withdrawn): go to IDLE with no ack and no counter update.
  - If gate and withdraw occur in the same cycle, gate wins.
- RUN: o_busy=1 and o_routine_request=0.
  - On i_last_cycle or i_break_out: if i_chain=1 and any i_req bit is set, re-arbitrate and go directly to PEND; otherwise go to IDLE.
  - i_chain has no effect unless i_last_cycle or i_break_out is asserted.
- Wait counters (4 bits each, saturating at MAXWAIT), updated on the gate event only:
  - The granted channel's counter is cleared.
  - Every other channel with i_req set is incremented.
  - In any advance cycle, a channel with i_req=0 has its counter cleared.
- A withdraw in PEND does not alter the latched id of any other channel. Re-arbitration occurs only from IDLE or on a chain exit from RUN.
- o_grant_id and o_boosted are stable from PEND entry until leaving RUN.

Decomposition:
- Shared package x2050_pkg holds:
  - the state encoding constants PRI_IDLE, PRI_PEND, PRI_RUN;
  - the channel index constants CH_SEL1..CH_MPX.
- One natural sub-module: x2050pri_pick. It is a purely combinational lowest-index-with-boost picker taking i_req and the boost vector, and returning id, any, and boosted.
- The counters and the FSM stay in x2050pri.

Test Plan:
- Basic grant and gate: reset, then i_req=4'b0100 → next advance gives PEND, o_grant_id=2, o_routine_request=1. Pulse i_gate_break_routine → RUN, then o_ack=4'b0100 for exactly 1 clock, o_busy=1. i_last_cycle → IDLE.
- Fixed priority: i_req=4'b1010 → o_grant_id=1. The wait counter for channel 3 is 1 after the gate.
- Starvation boost: hold i_req[3]=1 while cycling channel 0 through three full grants (MAXWAIT=3) → the 4th arbitration gives o_grant_id=3 and o_boosted=1, even though i_req[0]=1.
- Withdraw versus gate: in PEND for id 2, drop i_req[2] → IDLE and o_ack stays 0. Repeat with the drop and the gate in the same cycle → RUN and o_ack=4'b0100.
- Chain: in RUN for id 0 with i_req=4'b0010, assert i_break_out and i_chain together → direct to PEND with o_grant_id=1 and no IDLE cycle. Without i_chain → IDLE.
- Stall and reset: with i_ros_advance=0 for 5 clocks in PEND plus a gate → state holds and no ack. Assert i_reset mid-RUN → all outputs 0 on the next clock and counters cleared.

Source files
------------

// File: rtl/x2050_pkg.sv
// rtl/x2050_pkg.sv - shared state encoding and channel indices for the 2050 channel-priority scheduler
package x2050_pkg;

  // Scheduler states: waiting for a request, requesting break-in, routine running
  typedef enum logic [1:0] {
    PRI_IDLE = 2'd0,
    PRI_PEND = 2'd1,
    PRI_RUN  = 2'd2
  } pri_state_t;

  // Channel indices for the standard four-channel machine; lower index wins ties
  localparam int CH_SEL1 = 0;
  localparam int CH_SEL2 = 1;
  localparam int CH_SEL3 = 2;
  localparam int CH_MPX  = 3;

  // Width of each per-channel pass-over counter
  localparam int WAIT_W = 4;

endpackage

// File: rtl/x2050pri_pick.sv
// rtl/x2050pri_pick.sv - lowest-index request picker with starvation boost override
module x2050pri_pick #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic [NCH-1:0] i_req,
  input  logic [NCH-1:0] i_boost,
  output logic [IDW-1:0] o_id,
  output logic           o_any,
  output logic           o_boosted
);

  logic [NCH-1:0] boosted_req;
  logic [NCH-1:0] cand;

  // Boosted requesters shadow everyone else; within a class the lowest index wins
  always_comb begin
    boosted_req = i_req & i_boost;
    o_boosted   = |boosted_req;
    cand        = o_boosted ? boosted_req : i_req;
    o_any       = |i_req;
    o_id        = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) o_id = IDW'(i);
    end
  end

endmodule

// File: rtl/x2050pri.sv
// rtl/x2050pri.sv - channel-priority scheduler driving the 2050 break-in routine request
module x2050pri
  import x2050_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int IDW     = 2,
  parameter int MAXWAIT = 3
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_ros_advance,
  input  logic [NCH-1:0] i_req,
  input  logic           i_gate_break_routine,
  input  logic           i_last_cycle,
  input  logic           i_break_out,
  input  logic           i_chain,
  output logic           o_routine_request,
  output logic [IDW-1:0] o_grant_id,
  output logic           o_grant_valid,
  output logic [NCH-1:0] o_ack,
  output logic           o_busy,
  output logic           o_boosted
);

  localparam logic [WAIT_W-1:0] WMAX = WAIT_W'(MAXWAIT);

  pri_state_t                     state_q, state_d;
  logic [IDW-1:0]                 grant_id_q, grant_id_d;
  logic                           boosted_q, boosted_d;
  logic [NCH-1:0]                 ack_q, ack_d;
  logic [NCH-1:0][WAIT_W-1:0]     wait_q, wait_d;

  logic [NCH-1:0]                 boost_vec;
  logic [NCH-1:0]                 grant_mask;
  logic [IDW-1:0]                 pick_id;
  logic                           pick_any;
  logic                           pick_boosted;
  logic                           gate_evt;
  logic                           routine_end;

  // A channel is boosted once it has been passed over the maximum number of times
  always_comb begin
    boost_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      boost_vec[i] = (wait_q[i] == WMAX);
    end
  end

  x2050pri_pick #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_pick (
    .i_req     (i_req),
    .i_boost   (boost_vec),
    .o_id      (pick_id),
    .o_any     (pick_any),
    .o_boosted (pick_boosted)
  );

  assign grant_mask  = NCH'(1) << grant_id_q;
  assign routine_end = i_last_cycle | i_break_out;

  // Next-state logic: arbitrate from IDLE or on chain exit, hold the grant otherwise
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    boosted_d  = boosted_q;
    ack_d      = '0;
    gate_evt   = 1'b0;
    if (i_ros_advance) begin
      case (state_q)
        PRI_IDLE: begin
          if (pick_any) begin
            state_d    = PRI_PEND;
            grant_id_d = pick_id;
            boosted_d  = pick_boosted;
          end
        end
        PRI_PEND: begin
          if (i_gate_break_routine) begin
            state_d  = PRI_RUN;
            gate_evt = 1'b1;
            ack_d    = grant_mask;
          end else if ((i_req & grant_mask) == '0) begin
            state_d    = PRI_IDLE;
            grant_id_d = '0;
            boosted_d  = 1'b0;
          end
        end
        PRI_RUN: begin
          if (routine_end) begin
            if (i_chain && pick_any) begin
              state_d    = PRI_PEND;
              grant_id_d = pick_id;
              boosted_d  = pick_boosted;
            end else begin
              state_d    = PRI_IDLE;
              grant_id_d = '0;
              boosted_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d    = PRI_IDLE;
          grant_id_d = '0;
          boosted_d  = 1'b0;
        end
      endcase
    end
  end

  // Pass-over counters: idle channels forget, the gated winner restarts, losers age
  always_comb begin
    wait_d = wait_q;
    if (i_ros_advance) begin
      for (int i = 0; i < NCH; i++) begin
        if (!i_req[i]) begin
          wait_d[i] = '0;
        end else if (gate_evt) begin
          if (IDW'(i) == grant_id_q) begin
            wait_d[i] = '0;
          end else if (wait_q[i] < WMAX) begin
            wait_d[i] = wait_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // State register; the ack is rebuilt every clock so it can only ever pulse once
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= PRI_IDLE;
      grant_id_q <= '0;
      boosted_q  <= 1'b0;
      ack_q      <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      boosted_q  <= boosted_d;
      ack_q      <= ack_d;
      wait_q     <= wait_d;
    end
  end

  assign o_routine_request = (state_q == PRI_PEND);
  assign o_grant_valid     = (state_q == PRI_PEND) || (state_q == PRI_RUN);
  assign o_busy            = (state_q == PRI_RUN);
  assign o_grant_id        = grant_id_q;
  assign o_boosted         = boosted_q;
  assign o_ack             = ack_q;

endmodule

// File: tb/tb_x2050pri.sv
// tb/tb_x2050pri.sv - self-checking bench for the x2050pri channel-priority scheduler
module tb_x2050pri;

  localparam int NCH     = 4;
  localparam int IDW     = 2;
  localparam int MAXWAIT = 3;

  localparam int S_IDLE = 0;
  localparam int S_PEND = 1;
  localparam int S_RUN  = 2;

  logic           i_clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_ros_advance = 1'b0;
  logic [NCH-1:0] i_req = '0;
  logic           i_gate_break_routine = 1'b0;
  logic           i_last_cycle = 1'b0;
  logic           i_break_out = 1'b0;
  logic           i_chain = 1'b0;
  logic           o_routine_request;
  logic [IDW-1:0] o_grant_id;
  logic           o_grant_valid;
  logic [NCH-1:0] o_ack;
  logic           o_busy;
  logic           o_boosted;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  x2050pri #(
    .NCH     (NCH),
    .IDW     (IDW),
    .MAXWAIT (MAXWAIT)
  ) dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_ros_advance        (i_ros_advance),
    .i_req                (i_req),
    .i_gate_break_routine (i_gate_break_routine),
    .i_last_cycle         (i_last_cycle),
    .i_break_out          (i_break_out),
    .i_chain              (i_chain),
    .o_routine_request    (o_routine_request),
    .o_grant_id           (o_grant_id),
    .o_grant_valid        (o_grant_valid),
    .o_ack                (o_ack),
    .o_busy               (o_busy),
    .o_boosted            (o_boosted)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: scheduler state, latched grant, ack pulse and pass-over counts
  int       m_state = S_IDLE;
  int       m_id = 0;
  bit       m_boost = 1'b0;
  logic [NCH-1:0] m_ack = '0;
  int       m_wait [NCH];

  initial begin
    for (int i = 0; i < NCH; i++) m_wait[i] = 0;
  end

  // Model update on the same edge the DUT uses, from the inputs it sees
  always @(posedge i_clk) begin
    int win;
    bit wb;
    bit any;
    bit gate_evt;
    int old_id;
    m_ack = '0;
    if (i_reset) begin
      m_state = S_IDLE;
      m_id = 0;
      m_boost = 1'b0;
      for (int i = 0; i < NCH; i++) m_wait[i] = 0;
    end else if (i_ros_advance) begin
      any = (i_req != '0);
      win = -1;
      wb = 1'b0;
      for (int i = 0; i < NCH; i++)
        if (win < 0 && i_req[i] && m_wait[i] == MAXWAIT) begin win = i; wb = 1'b1; end
      for (int i = 0; i < NCH; i++)
        if (win < 0 && i_req[i]) win = i;
      old_id = m_id;
      gate_evt = (m_state == S_PEND) && i_gate_break_routine;
      for (int i = 0; i < NCH; i++) begin
        if (!i_req[i]) m_wait[i] = 0;
        else if (gate_evt) m_wait[i] = (i == old_id) ? 0 : ((m_wait[i] < MAXWAIT) ? m_wait[i] + 1 : MAXWAIT);
      end
      case (m_state)
        S_IDLE: if (any) begin m_state = S_PEND; m_id = win; m_boost = wb; end
        S_PEND: begin
          if (i_gate_break_routine) begin
            m_state = S_RUN;
            m_ack = NCH'(1) << old_id;
          end else if (!i_req[old_id]) begin
            m_state = S_IDLE; m_id = 0; m_boost = 1'b0;
          end
        end
        default: begin
          if (i_last_cycle || i_break_out) begin
            if (i_chain && any) begin m_state = S_PEND; m_id = win; m_boost = wb; end
            else begin m_state = S_IDLE; m_id = 0; m_boost = 1'b0; end
          end
        end
      endcase
    end
  end

  // Compare every output with the model away from the active edge
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("routine_request", 32'(o_routine_request), 32'(m_state == S_PEND));
      chk("grant_valid", 32'(o_grant_valid), 32'(m_state != S_IDLE));
      chk("busy", 32'(o_busy), 32'(m_state == S_RUN));
      chk("grant_id", 32'(o_grant_id), 32'(m_id));
      chk("boosted", 32'(o_boosted), 32'(m_boost));
      chk("ack", 32'(o_ack), 32'(m_ack));
    end
  end

  task automatic step(input logic rst, input logic adv, input logic [NCH-1:0] req,
                      input logic gate, input logic last, input logic brk, input logic chn);
    i_reset = rst;
    i_ros_advance = adv;
    i_req = req;
    i_gate_break_routine = gate;
    i_last_cycle = last;
    i_break_out = brk;
    i_chain = chn;
    @(posedge i_clk);
    #1;
  endtask

  logic [NCH-1:0] rreq;

  initial begin
    // Reset and idle state
    step(1, 1, 4'b0000, 0, 0, 0, 0);
    step(1, 1, 4'b0000, 0, 0, 0, 0);
    cmp_en = 1'b1;
    chk("rst_rr", 32'(o_routine_request), 0);
    chk("rst_valid", 32'(o_grant_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_ack", 32'(o_ack), 0);

    // Basic grant and gate
    step(0, 1, 4'b0100, 0, 0, 0, 0);
    chk("basic_rr", 32'(o_routine_request), 1);
    chk("basic_id", 32'(o_grant_id), 2);
    step(0, 1, 4'b0100, 1, 0, 0, 0);
    chk("basic_busy", 32'(o_busy), 1);
    chk("basic_ack", 32'(o_ack), 32'b0100);
    step(0, 1, 4'b0100, 0, 0, 0, 0);
    chk("basic_ack_clear", 32'(o_ack), 0);
    step(0, 1, 4'b0000, 0, 1, 0, 0);
    chk("basic_idle", 32'(o_grant_valid), 0);

    // Fixed priority
    step(0, 1, 4'b1010, 0, 0, 0, 0);
    chk("prio_id", 32'(o_grant_id), 1);
    step(0, 1, 4'b1010, 1, 0, 0, 0);
    chk("prio_ack", 32'(o_ack), 32'b0010);
    step(0, 1, 4'b0000, 0, 1, 0, 0);

    // Starvation boost: channel 3 passed over three times
    step(1, 1, 4'b0000, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 4'b1001, 0, 0, 0, 0);
      chk("starve_id0", 32'(o_grant_id), 0);
      chk("starve_noboost", 32'(o_boosted), 0);
      step(0, 1, 4'b1001, 1, 0, 0, 0);
      step(0, 1, 4'b1001, 0, 1, 0, 0);
    end
    step(0, 1, 4'b1001, 0, 0, 0, 0);
    chk("boost_id", 32'(o_grant_id), 3);
    chk("boost_flag", 32'(o_boosted), 1);
    step(0, 1, 4'b1001, 1, 0, 0, 0);
    chk("boost_ack", 32'(o_ack), 32'b1000);
    step(0, 1, 4'b0000, 0, 1, 0, 0);

    // Withdraw alone, then withdraw together with gate
    step(0, 1, 4'b0100, 0, 0, 0, 0);
    step(0, 1, 4'b0000, 0, 0, 0, 0);
    chk("withdraw_idle", 32'(o_grant_valid), 0);
    chk("withdraw_noack", 32'(o_ack), 0);
    step(0, 1, 4'b0100, 0, 0, 0, 0);
    step(0, 1, 4'b0000, 1, 0, 0, 0);
    chk("gatewins_busy", 32'(o_busy), 1);
    chk("gatewins_ack", 32'(o_ack), 32'b0100);
    step(0, 1, 4'b0000, 0, 1, 0, 0);

    // Chain directly into the next routine, then exit without chain
    step(0, 1, 4'b0001, 0, 0, 0, 0);
    step(0, 1, 4'b0001, 1, 0, 0, 0);
    step(0, 1, 4'b0010, 0, 0, 1, 1);
    chk("chain_rr", 32'(o_routine_request), 1);
    chk("chain_id", 32'(o_grant_id), 1);
    step(0, 1, 4'b0010, 1, 0, 0, 0);
    step(0, 1, 4'b0010, 0, 0, 1, 0);
    chk("nochain_idle", 32'(o_grant_valid), 0);

    // Stall in PEND with gate held, then release
    step(0, 1, 4'b0100, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 4'b0100, 1, 0, 0, 0);
      chk("stall_rr", 32'(o_routine_request), 1);
      chk("stall_noack", 32'(o_ack), 0);
    end
    step(0, 1, 4'b0100, 1, 0, 0, 0);
    chk("stall_release_ack", 32'(o_ack), 32'b0100);
    step(1, 1, 4'b0100, 0, 0, 0, 0);
    chk("midrun_reset_busy", 32'(o_busy), 0);
    chk("midrun_reset_valid", 32'(o_grant_valid), 0);

    // Randomized traffic against the model
    rreq = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NCH; b++)
        if ($urandom_range(0, 99) < 15) rreq[b] = ~rreq[b];
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 85),
           rreq,
           ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 50));
    end

    @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
